// File: rtl/register_file_if.sv
// Register-file access bundle: two read index/data pairs and one write port.
// The writeback/decode side is the master; the register file is the slave.
interface register_file_if #(
  parameter int SIZE = 64
);
  logic [4:0]      read_reg1;
  logic [4:0]      read_reg2;
  logic [4:0]      write_reg;
  logic [SIZE-1:0] write_data;
  logic            reg_write;
  logic [SIZE-1:0] read_data1;
  logic [SIZE-1:0] read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2
  );
endinterface

// File: rtl/register_file.sv
// ARM64 integer register file: X0..X30 stored, X31 (XZR) reads zero; 1W/2R, combinational reads.
// Optional same-cycle write->read forwarding is enabled by defining REGFILE_BYPASS_EN.
module mux32x1 #(
  parameter int SIZE = 64
) (
  input  logic [SIZE-1:0] in_data [32],
  input  logic [4:0]      sel,
  output logic [SIZE-1:0] out_data
);
  assign out_data = in_data[sel];
endmodule

module register_file #(
  parameter int SIZE = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  register_file_if.slave bus
);
  logic [SIZE-1:0] regs_q [31];
  logic [SIZE-1:0] regs_d [31];
  logic [31:0]     we_onehot;
  logic [SIZE-1:0] mux_in [32];
  logic [SIZE-1:0] mux_out1;
  logic [SIZE-1:0] mux_out2;

  // XZR has no storage, so its decode bit is forced low.
  always_comb begin
    we_onehot = '0;
    if (bus.reg_write) begin
      we_onehot[bus.write_reg] = 1'b1;
    end
    we_onehot[31] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < 31; i++) begin
      regs_d[i] = we_onehot[i] ? bus.write_data : regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 31; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 31; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 31; i++) begin
      mux_in[i] = regs_q[i];
    end
    mux_in[31] = '0;
  end

  mux32x1 #(.SIZE(SIZE)) u_rd_mux1 (
    .in_data  (mux_in),
    .sel      (bus.read_reg1),
    .out_data (mux_out1)
  );

  mux32x1 #(.SIZE(SIZE)) u_rd_mux2 (
    .in_data  (mux_in),
    .sel      (bus.read_reg2),
    .out_data (mux_out2)
  );

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  // Forwarding is held off during reset so the outputs stay zero.
  assign byp1 = reset_n && bus.reg_write && (bus.write_reg == bus.read_reg1) && (bus.write_reg != 5'd31);
  assign byp2 = reset_n && bus.reg_write && (bus.write_reg == bus.read_reg2) && (bus.write_reg != 5'd31);

  assign bus.read_data1 = byp1 ? bus.write_data : mux_out1;
  assign bus.read_data2 = byp2 ? bus.write_data : mux_out2;
`else
  assign bus.read_data1 = mux_out1;
  assign bus.read_data2 = mux_out2;
`endif
endmodule
